// File: rtl/alu_slice_sequencer.sv
// Multi-cycle sequencer that runs a WIDTH-bit ALU operation through one shared
// SLICE-bit 74181-style slice, LSB chunk first, rippling the carry between chunks.
module alu_slice_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_s,
  input  logic             cmd_m,
  input  logic             cmd_cin,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [SLICE-1:0] alu_a,
  output logic [SLICE-1:0] alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [SLICE-1:0] alu_f,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cout,
  output logic             res_zero,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST       = CW'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] f_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             in_run;
  logic             in_done;
  logic             in_idle;
  logic             accept;
  logic             last;
  logic [31:0]      shamt;

  // The unused encoding is treated exactly like IDLE.
  assign in_run  = (state == RUN);
  assign in_done = (state == DONE);
  assign in_idle = !(in_run || in_done);
  assign accept  = in_idle && cmd_valid;
  assign last    = (cnt == LAST);
  assign shamt   = 32'(cnt) * 32'(SLICE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    cmd_ready = in_idle;
    busy      = !in_idle;
    res_valid = in_done;
    res_f     = f_reg;
    res_cout  = carry_reg & ~m_reg;
    res_zero  = (f_reg == '0);
    alu_s     = s_reg;
    alu_m     = m_reg;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN: begin
        state_nxt = last ? DONE : RUN;
        alu_a     = SLICE'(a_reg >> shamt);
        alu_b     = SLICE'(b_reg >> shamt);
        alu_cin   = carry_reg;
      end
      DONE:    state_nxt = res_ready ? IDLE : DONE;
      default: state_nxt = accept ? RUN : IDLE;
    endcase
  end

  // Each RUN cycle stores the slice result into its chunk and keeps the carry for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      f_reg     <= '0;
      s_reg     <= '0;
      m_reg     <= 1'b0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_reg     <= cmd_a;
      b_reg     <= cmd_b;
      s_reg     <= cmd_s;
      m_reg     <= cmd_m;
      carry_reg <= cmd_cin;
      cnt       <= '0;
    end else if (in_run) begin
      f_reg     <= (f_reg & ~(CHUNK_MASK << shamt)) | (WIDTH'(alu_f) << shamt);
      carry_reg <= alu_cout;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed self-checking bench for alu_slice_sequencer with a behavioural
// 4-bit slice model (add when m=0/s=1001, xor when m=1/s=0110).
module tb_alu_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_s;
  logic        cmd_m;
  logic        cmd_cin;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic        alu_cin;
  logic [3:0]  alu_f;
  logic        alu_cout;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_f;
  logic        res_cout;
  logic        res_zero;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_XOR = 4'b0110;

  alu_slice_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_cout(res_cout), .res_zero(res_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // The carry chain runs in logic mode too, so a final carry can appear that the sequencer must mask.
  logic [4:0] sliceSum;
  always_comb begin
    sliceSum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    alu_cout = sliceSum[4];
    alu_f    = 4'h0;
    if (!alu_m && alu_s == S_ADD)     alu_f = sliceSum[3:0];
    else if (alu_m && alu_s == S_XOR) alu_f = alu_a ^ alu_b;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic m, input logic cin,
                               input logic [15:0] a, input logic [15:0] b);
    cmd_s     = s;
    cmd_m     = m;
    cmd_cin   = cin;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    checkOutput("cmd_ready_at_offer", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runToDone(output int cycles, output logic [3:0] cins);
    cycles = 0;
    cins   = 4'h0;
    while (!res_valid && cycles < 20) begin
      if (cycles < 4) cins[cycles] = alu_cin;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic releaseResult();
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_res_valid", 32'(res_valid), 32'd0);
    checkOutput("release_cmd_ready", 32'(cmd_ready), 32'd1);
    res_ready = 1'b0;
  endtask

  initial begin
    int         cycles;
    logic [3:0] cins;
    int         sawValid;
    logic [15:0] bbA [3];
    logic [15:0] bbB [3];
    logic [15:0] bbF [3];
    logic        bbC [3];

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_s     = 4'h0;
    cmd_m     = 1'b0;
    cmd_cin   = 1'b0;
    cmd_a     = 16'h0;
    cmd_b     = 16'h0;

    #2;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_res_f", 32'(res_f), 32'd0);
    checkOutput("reset_res_cout", 32'(res_cout), 32'd0);
    checkOutput("reset_res_zero", 32'(res_zero), 32'd1);
    checkOutput("reset_alu", {20'd0, alu_a, alu_b, alu_s}, 32'd0);
    checkOutput("reset_alu_m_cin", {30'd0, alu_m, alu_cin}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x00FF + 0x0001: carries ripple out of chunks 0 and 1 only.
    applyStimulus(S_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    checkOutput("add1_busy", 32'(busy), 32'd1);
    runToDone(cycles, cins);
    checkOutput("add1_latency", 32'(cycles), 32'd4);
    checkOutput("add1_cin_seq", 32'(cins), 32'b0110);
    checkOutput("add1_res_f", 32'(res_f), 32'h0100);
    checkOutput("add1_res_cout", 32'(res_cout), 32'd0);
    checkOutput("add1_res_zero", 32'(res_zero), 32'd0);
    checkOutput("add1_cmd_ready", 32'(cmd_ready), 32'd0);
    releaseResult();

    applyStimulus(S_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    runToDone(cycles, cins);
    checkOutput("add2_latency", 32'(cycles), 32'd4);
    checkOutput("add2_res_f", 32'(res_f), 32'h0000);
    checkOutput("add2_res_cout", 32'(res_cout), 32'd1);
    checkOutput("add2_res_zero", 32'(res_zero), 32'd1);
    releaseResult();

    applyStimulus(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0000);
    runToDone(cycles, cins);
    checkOutput("add3_res_f", 32'(res_f), 32'h1235);
    checkOutput("add3_res_cout", 32'(res_cout), 32'd0);
    checkOutput("add3_res_zero", 32'(res_zero), 32'd0);
    releaseResult();

    // Logic mode whose add-chain carries all the way out; the final carry must be masked.
    applyStimulus(S_XOR, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
    checkOutput("xor1_alu_m", 32'(alu_m), 32'd1);
    runToDone(cycles, cins);
    checkOutput("xor1_res_f", 32'(res_f), 32'hFFFE);
    checkOutput("xor1_res_cout", 32'(res_cout), 32'd0);
    releaseResult();

    // XOR held in DONE under backpressure while a stray command is offered.
    applyStimulus(S_XOR, 1'b1, 1'b0, 16'hA5A5, 16'h0FF0);
    runToDone(cycles, cins);
    checkOutput("xor2_latency", 32'(cycles), 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cmd_s     = S_ADD;
        cmd_m     = 1'b0;
        cmd_a     = 16'h1111;
        cmd_b     = 16'h1111;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_res_f", 32'(res_f), 32'hAA55);
      checkOutput("bp_res_cout", 32'(res_cout), 32'd0);
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checkOutput("bp_still_done", 32'(res_valid), 32'd1);
    releaseResult();
    checkOutput("bp_not_consumed_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("bp_idle_stays", 32'(busy), 32'd0);

    // Abort mid-RUN at cnt = 2 with an asynchronous reset between edges.
    applyStimulus(S_ADD, 1'b0, 1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    checkOutput("run_cnt2_alu_a", 32'(alu_a), 32'd1);
    checkOutput("run_cnt2_alu_b", 32'(alu_b), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_res_f", 32'(res_f), 32'd0);
    checkOutput("abort_res_zero", 32'(res_zero), 32'd1);
    checkOutput("abort_alu", {23'd0, alu_a, alu_b, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) sawValid++;
    end
    checkOutput("abort_no_res_valid", 32'(sawValid), 32'd0);
    applyStimulus(S_ADD, 1'b0, 1'b0, 16'h0003, 16'h0004);
    runToDone(cycles, cins);
    checkOutput("post_abort_res_f", 32'(res_f), 32'h0007);
    releaseResult();

    // Back-to-back with cmd_valid and res_ready held high: an accept every 6 cycles.
    bbA[0] = 16'h0101; bbB[0] = 16'h0202; bbF[0] = 16'h0303; bbC[0] = 1'b0;
    bbA[1] = 16'h7FFF; bbB[1] = 16'h0001; bbF[1] = 16'h8000; bbC[1] = 1'b0;
    bbA[2] = 16'hFFFF; bbB[2] = 16'hFFFF; bbF[2] = 16'hFFFE; bbC[2] = 1'b1;
    res_ready = 1'b1;
    cmd_s     = S_ADD;
    cmd_m     = 1'b0;
    cmd_cin   = 1'b0;
    cmd_a     = bbA[0];
    cmd_b     = bbB[0];
    cmd_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmd_a    = (k < 2) ? bbA[k+1] : 16'h0;
      cmd_b    = (k < 2) ? bbB[k+1] : 16'h0;
      if (k == 2) cmd_valid = 1'b0;
      cycles   = 0;
      sawValid = 0;
      do begin
        @(negedge clk);
        cycles++;
        if (res_valid) begin
          sawValid++;
          checkOutput("b2b_res_f", 32'(res_f), 32'(bbF[k]));
          checkOutput("b2b_res_cout", 32'(res_cout), 32'(bbC[k]));
        end
      end while (!cmd_ready && cycles < 20);
      checkOutput("b2b_spacing", 32'(cycles + 1), 32'd6);
      checkOutput("b2b_one_result", 32'(sawValid), 32'd1);
      if (k < 2) @(negedge clk);
    end
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Multi-cycle controller that runs a WIDTH-bit ALU operation on one shared SLICE-bit ALU slice (the 74181-style s3..s0/m/carry slice built from the g/p bit cells). It accepts a command over a valid/ready handshake, then feeds the slice one SLICE-bit chunk per cycle, LSB chunk first, carrying alu_cout into the next chunk's alu_cin. It assembles the result and returns it over a second valid/ready handshake. It sits between the instruction decode / register file and the ALU slice.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, width of the external ALU slice; N = WIDTH/SLICE chunks, N ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_s  in  4  ALU select s3..s0.
- cmd_m  in  1  mode: 1 = logic, 0 = arithmetic.
- cmd_cin  in  1  carry into chunk 0.
- cmd_a, cmd_b  in  WIDTH  operands.
- alu_a, alu_b  out  SLICE  chunk operands to the slice.
- alu_s  out  4  select to the slice.
- alu_m  out  1  mode to the slice.
- alu_cin  out  1  carry to the slice.
- alu_f  in  SLICE  slice result (combinational from alu_* outputs).
- alu_cout  in  1  slice carry out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_f  out  WIDTH  assembled result.
- res_cout  out  1  final carry; forced 0 when m = 1.
- res_zero  out  1  res_f == 0.
- busy  out  1  state ≠ IDLE.

## Operation
- Registers:
  - a_reg, b_reg, s_reg, m_reg: latched command.
  - carry_reg: running carry.
  - cnt: 0..N-1.
  - f_reg: result.
  - state.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch a/b/s/m, set carry_reg = cmd_cin, cnt = 0, go to RUN.
- RUN:
  - alu_a = a_reg[cnt*SLICE +: SLICE], alu_b = b_reg[cnt*SLICE +: SLICE], alu_s = s_reg, alu_m = m_reg, alu_cin = carry_reg.
  - Each clock edge: f_reg[cnt*SLICE +: SLICE] ← alu_f, carry_reg ← alu_cout.
  - If cnt == N-1, go to DONE; otherwise cnt ← cnt+1.
- DONE:
  - res_valid = 1; res_f = f_reg; res_cout = carry_reg & ~m_reg; res_zero = (f_reg == 0).
  - On res_ready go to IDLE.
- Outside RUN: alu_a = alu_b = 0, alu_cin = 0; alu_s and alu_m show s_reg and m_reg.
- cmd_ready = 1 only in IDLE. cmd_valid in RUN/DONE is ignored and the command is not consumed.
- res_f, res_cout and res_zero stay stable throughout DONE regardless of res_ready timing or cmd inputs.
- In logic mode the carry chain still propagates, but the result ignores it.
- Invalid states decode to IDLE.

## Timing
- Reset (async assert, takes effect without a clock edge):
  - state = IDLE, cnt = 0, all data registers = 0.
  - Outputs: cmd_ready = 1, res_valid = 0, busy = 0, res_f = 0, res_cout = 0, res_zero = 1, alu_* = 0.
- Reset during RUN or DONE aborts the operation; no res_valid is produced for it.
- Latency: command accepted at edge E0 → RUN for edges E1..EN → res_valid high after edge EN, i.e. N cycles after acceptance. For N = 1 there is a single RUN cycle.
- res_valid drops at the edge where res_valid & res_ready; cmd_ready rises at that same edge.
- Minimum command spacing: N+2 cycles (accept, N × RUN, DONE) with res_ready tied high.
- All outputs are registered-state decodes. The only combinational input→output path is the external one, alu_* → alu_f.

## Test plan
Bench slice model: m = 0 with s = 1001 gives F = A+B+cin; m = 1 with s = 0110 gives F = A^B. WIDTH = 16, SLICE = 4.
- Add 0x00FF + 0x0001, cin = 0 → res_f = 0x0100, res_cout = 0, res_zero = 0; res_valid exactly 4 cycles after accept; alu_cin sequence 0,1,1,0.
- Add 0xFFFF + 0x0001, cin = 0 → res_f = 0x0000, res_cout = 1, res_zero = 1. Add 0x1234 + 0x0000, cin = 1 → 0x1235, res_cout = 0.
- Logic XOR 0xA5A5 ^ 0x0FF0 (m = 1) → res_f = 0xAA55, res_cout = 0 even though the chain carries.
- Backpressure: hold res_ready = 0 for 5 cycles in DONE → res_valid, res_f and res_cout stay stable, cmd_ready = 0; a cmd_valid pulse meanwhile is not accepted. Releasing res_ready → IDLE next edge.
- Assert rst_n = 0 mid-RUN at cnt = 2 → outputs immediately at reset values, no res_valid. After release, 0x0003 + 0x0004 → 0x0007.
- Back-to-back commands with cmd_valid and res_ready held high → one accept every 6 cycles, each result correct.
